// File: rtl/sdram_arb_pkg.sv
// Shared constants and types for the SDRAM wishbone arbiter.
package sdram_arb_pkg;

  localparam int unsigned NumMasters = 3;

  localparam int unsigned M_VIDEO = 0;
  localparam int unsigned M_SOUND = 1;
  localparam int unsigned M_CPU   = 2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    StDrain,
    StIdle,
    StOwn,
    StGap
  } arb_state_e;

  // Isolates the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [2:0] lowest_onehot(input logic [2:0] req);
    return req & (~req + 3'd1);
  endfunction

endpackage

// File: rtl/sdram_arb_prio.sv
// Fixed-priority winner select (M0 > M1 > M2).
// With ARB_STARVE_GUARD_EN defined, a saturating wait counter promotes a starved M2.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       cpu_owner,
  output logic [2:0] winner
);

`ifdef ARB_STARVE_GUARD_EN
  logic [4:0] starve_cnt_q, starve_cnt_d;
  logic       starved;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (cpu_owner) begin
      starve_cnt_d = '0;
    end else if (req[M_CPU] && (starve_cnt_q < 5'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starved = (starve_cnt_q == 5'(STARVE_LIMIT));
  assign winner  = (starved && req[M_CPU]) ? 3'b100 : lowest_onehot(req);
`else
  logic unused_guard;
  assign unused_guard = ^{clk, rst_n, cpu_owner, 5'(STARVE_LIMIT)};
  assign winner       = lowest_onehot(req);
`endif

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Three-master wishbone arbiter in front of the SDRAM controller; grant held per cycle,
// one-cycle bus gap after each release. Optional M2 starvation guard: ARB_STARVE_GUARD_EN.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADR_W        = 24,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_dat_i,
  output logic [31:0]      m0_dat_o,
  input  logic [3:0]       m0_sel,
  input  logic [2:0]       m0_cti,
  input  logic             m0_stb,
  input  logic             m0_cyc,
  input  logic             m0_we,
  output logic             m0_ack,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_dat_i,
  output logic [31:0]      m1_dat_o,
  input  logic [3:0]       m1_sel,
  input  logic [2:0]       m1_cti,
  input  logic             m1_stb,
  input  logic             m1_cyc,
  input  logic             m1_we,
  output logic             m1_ack,
  input  logic [ADR_W-1:0] m2_adr,
  input  logic [31:0]      m2_dat_i,
  output logic [31:0]      m2_dat_o,
  input  logic [3:0]       m2_sel,
  input  logic [2:0]       m2_cti,
  input  logic             m2_stb,
  input  logic             m2_cyc,
  input  logic             m2_we,
  output logic             m2_ack,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_dat_o,
  input  logic [31:0]      s_dat_i,
  output logic [3:0]       s_sel,
  output logic [2:0]       s_cti,
  output logic             s_stb,
  output logic             s_cyc,
  output logic             s_we,
  input  logic             s_ack,
  output logic [2:0]       grant
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  logic [ADR_W-1:0] adr  [NumMasters];
  logic [31:0]      wdat [NumMasters];
  logic [31:0]      rdat [NumMasters];
  logic [3:0]       sel  [NumMasters];
  logic [2:0]       cti  [NumMasters];
  logic [2:0]       stb, cyc, we, ack, req, winner;

  arb_state_e        state_q, state_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [2:0]        grant_q, grant_d;
  logic              owner_cyc;

  assign adr[M_VIDEO]  = m0_adr;
  assign adr[M_SOUND]  = m1_adr;
  assign adr[M_CPU]    = m2_adr;
  assign wdat[M_VIDEO] = m0_dat_i;
  assign wdat[M_SOUND] = m1_dat_i;
  assign wdat[M_CPU]   = m2_dat_i;
  assign sel[M_VIDEO]  = m0_sel;
  assign sel[M_SOUND]  = m1_sel;
  assign sel[M_CPU]    = m2_sel;
  assign cti[M_VIDEO]  = m0_cti;
  assign cti[M_SOUND]  = m1_cti;
  assign cti[M_CPU]    = m2_cti;
  assign stb           = {m2_stb, m1_stb, m0_stb};
  assign cyc           = {m2_cyc, m1_cyc, m0_cyc};
  assign we            = {m2_we, m1_we, m0_we};

  assign req       = cyc & stb;
  assign owner_cyc = |(cyc & grant_q);
  assign grant     = grant_q;

  sdram_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .req       (req),
    .cpu_owner (grant_q[M_CPU]),
    .winner    (winner)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= StDrain;
      drain_cnt_q <= DrainW'(DRAIN_CYCLES - 1);
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      grant_q     <= grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    grant_d     = grant_q;
    unique case (state_q)
      StDrain: begin
        if (drain_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q - DrainW'(1);
        end
      end
      StIdle: begin
        if (|req) begin
          state_d = StOwn;
          grant_d = winner;
        end
      end
      StOwn: begin
        // Only cyc ends ownership; burst beats are never counted.
        if (!owner_cyc) begin
          state_d = StGap;
          grant_d = '0;
        end
      end
      StGap: state_d = StIdle;
      default: state_d = StDrain;
    endcase
  end

  // grant_q is zero outside StOwn, so acks and data in other states fall away here.
  always_comb begin
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    s_cti   = '0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    s_we    = 1'b0;
    ack     = '0;
    for (int n = 0; n < NumMasters; n++) begin
      rdat[n] = '0;
      if (grant_q[n] && (state_q == StOwn)) begin
        s_adr   = adr[n];
        s_dat_o = wdat[n];
        s_sel   = sel[n];
        s_cti   = cti[n];
        s_stb   = stb[n];
        s_cyc   = cyc[n];
        s_we    = we[n];
        ack[n]  = s_ack;
        rdat[n] = s_dat_i;
      end
    end
  end

  assign m0_ack   = ack[M_VIDEO];
  assign m1_ack   = ack[M_SOUND];
  assign m2_ack   = ack[M_CPU];
  assign m0_dat_o = rdat[M_VIDEO];
  assign m1_dat_o = rdat[M_SOUND];
  assign m2_dat_o = rdat[M_CPU];

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Randomized bench for sdram_wb_arbiter against an ownership/timing reference model.
`timescale 1ns/1ps
module tb_sdram_wb_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned ADR_W = 24;
  localparam int DRAIN = 8;
  localparam int LIMIT = 16;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [3:0]       sel;
    logic [31:0]      dat;
    int               beats;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADR_W-1:0] m_adr  [3];
  logic [31:0]      m_wdat [3];
  logic [31:0]      m_rdat [3];
  logic [3:0]       m_sel  [3];
  logic [2:0]       m_cti  [3];
  logic [2:0]       m_stb, m_cyc, m_we, m_ack;
  logic             m0_ack_w, m1_ack_w, m2_ack_w;
  logic [31:0]      m0_rdat_w, m1_rdat_w, m2_rdat_w;
  logic [ADR_W-1:0] s_adr;
  logic [31:0]      s_dat_o, s_dat_i;
  logic [3:0]       s_sel;
  logic [2:0]       s_cti, grant;
  logic             s_stb, s_cyc, s_we, s_ack;

  assign m_ack     = {m2_ack_w, m1_ack_w, m0_ack_w};
  assign m_rdat[0] = m0_rdat_w;
  assign m_rdat[1] = m1_rdat_w;
  assign m_rdat[2] = m2_rdat_w;

  sdram_wb_arbiter #(.ADR_W(ADR_W), .DRAIN_CYCLES(DRAIN), .STARVE_LIMIT(LIMIT)) dut (
    .wb_clk   (clk),       .wb_rst_n (rst_n),
    .m0_adr   (m_adr[0]),  .m0_dat_i (m_wdat[0]), .m0_dat_o (m0_rdat_w), .m0_sel (m_sel[0]),
    .m0_cti   (m_cti[0]),  .m0_stb   (m_stb[0]),  .m0_cyc   (m_cyc[0]),  .m0_we  (m_we[0]),
    .m0_ack   (m0_ack_w),
    .m1_adr   (m_adr[1]),  .m1_dat_i (m_wdat[1]), .m1_dat_o (m1_rdat_w), .m1_sel (m_sel[1]),
    .m1_cti   (m_cti[1]),  .m1_stb   (m_stb[1]),  .m1_cyc   (m_cyc[1]),  .m1_we  (m_we[1]),
    .m1_ack   (m1_ack_w),
    .m2_adr   (m_adr[2]),  .m2_dat_i (m_wdat[2]), .m2_dat_o (m2_rdat_w), .m2_sel (m_sel[2]),
    .m2_cti   (m_cti[2]),  .m2_stb   (m_stb[2]),  .m2_cyc   (m_cyc[2]),  .m2_we  (m_we[2]),
    .m2_ack   (m2_ack_w),
    .s_adr    (s_adr),     .s_dat_o  (s_dat_o),   .s_dat_i  (s_dat_i),   .s_sel  (s_sel),
    .s_cti    (s_cti),     .s_stb    (s_stb),     .s_cyc    (s_cyc),     .s_we   (s_we),
    .s_ack    (s_ack),     .grant    (grant)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, and the earliest cycle a new arbitration may happen.
  int owner, t, arb_at, starve;

  // Bench-side masters and slave.
  txn_t        txq [3][$];
  txn_t        cur [3];
  logic [31:0] rx  [3][$];
  bit          busy [3];
  bit          cool [3];
  int          beats_left [3];
  int          ack_mode = 1;  // 0 random, 1 always, 2 never
  bit          noise_en = 1'b0;
  int          stray_at = -1;
  logic [31:0] slave_data [$];
  logic [2:0]  prev_grant = 3'b000;
  logic [2:0]  grant_log [$];
  int          first_grant_t = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic txn_t mk(input logic [ADR_W-1:0] adr, input logic we, input logic [3:0] sel,
                              input logic [31:0] dat, input int beats);
    txn_t x;
    x.adr = adr; x.we = we; x.sel = sel; x.dat = dat; x.beats = beats;
    return x;
  endfunction

  function automatic int pick(input logic [2:0] req, input int wait_cnt);
    if (GUARD && wait_cnt >= LIMIT && req[2]) return 2;
    for (int i = 0; i < 3; i++) if (req[i]) return i;
    return -1;
  endfunction

  // One bus cycle, entered and left at a negedge.
  task automatic step();
    logic [2:0]       req, e_ack, e_grant;
    logic             e_cyc, e_stb, e_we;
    logic [ADR_W-1:0] e_adr;
    logic [3:0]       e_sel;
    logic [2:0]       e_cti;
    logic [31:0]      e_dat;
    logic [31:0]      got_rdat [3];
    int               nxt;
    for (int i = 0; i < 3; i++) begin
      if (!busy[i] && !cool[i] && txq[i].size() > 0) begin
        cur[i] = txq[i].pop_front();
        busy[i] = 1'b1;
        beats_left[i] = cur[i].beats;
      end
      cool[i]   = 1'b0;
      m_adr[i]  = cur[i].adr;
      m_we[i]   = cur[i].we;
      m_sel[i]  = cur[i].sel;
      m_wdat[i] = cur[i].dat;
      m_cti[i]  = (cur[i].beats == 2) ? ((beats_left[i] == 2) ? CTI_INCR : CTI_END) : CTI_CLASSIC;
      m_cyc[i]  = busy[i];
      m_stb[i]  = busy[i] | (noise_en && $urandom_range(7) == 0);
    end
    #1;
    if (ack_mode == 1) s_ack = s_cyc & s_stb;
    else if (ack_mode == 2) s_ack = 1'b0;
    else s_ack = (s_cyc && s_stb && $urandom_range(3) != 0) || (!s_cyc && $urandom_range(15) == 0);
    if (t == stray_at) s_ack = 1'b1;
    s_dat_i = $urandom();
    if (s_ack && slave_data.size() > 0) s_dat_i = slave_data.pop_front();
    #1;
    e_grant = (owner >= 0) ? 3'(1 << owner) : 3'b000;
    if (owner >= 0) begin
      e_cyc = m_cyc[owner]; e_stb = m_stb[owner]; e_we = m_we[owner]; e_adr = m_adr[owner];
      e_sel = m_sel[owner]; e_cti = m_cti[owner]; e_dat = m_wdat[owner];
    end else begin
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_cti = '0; e_dat = '0;
    end
    for (int i = 0; i < 3; i++) e_ack[i] = (owner == i) && s_ack;
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("s_cyc", 32'(s_cyc), 32'(e_cyc));
    check_eq("s_stb", 32'(s_stb), 32'(e_stb));
    check_eq("s_we", 32'(s_we), 32'(e_we));
    check_eq("s_adr", 32'(s_adr), 32'(e_adr));
    check_eq("s_sel", 32'(s_sel), 32'(e_sel));
    check_eq("s_cti", 32'(s_cti), 32'(e_cti));
    check_eq("s_dat_o", s_dat_o, e_dat);
    check_eq("m_ack", 32'(m_ack), 32'(e_ack));
    for (int i = 0; i < 3; i++) begin
      got_rdat[i] = m_rdat[i];
      check_eq("m_dat_o", m_rdat[i], (owner == i) ? s_dat_i : 32'h0);
    end
    if (grant != 3'b000 && prev_grant == 3'b000) begin
      grant_log.push_back(grant);
      if (first_grant_t < 0) first_grant_t = t;
    end
    prev_grant = grant;
    @(posedge clk);
    req = m_cyc & m_stb;
    nxt = owner;
    if (owner >= 0) begin
      if (!m_cyc[owner]) begin
        nxt = -1;
        arb_at = t + 2;
      end
    end else if (t >= arb_at && req != 3'b000) begin
      nxt = pick(req, starve);
    end
    if (owner == 2) starve = 0;
    else if (req[2] && starve < LIMIT) starve++;
    owner = nxt;
    for (int i = 0; i < 3; i++) begin
      if (e_ack[i] && busy[i]) begin
        rx[i].push_back(got_rdat[i]);
        beats_left[i]--;
        if (beats_left[i] == 0) begin
          busy[i] = 1'b0;
          cool[i] = 1'b1;
        end
      end
    end
    t++;
    @(negedge clk);
  endtask

  task automatic reset_checks();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_s_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_s_stb", 32'(s_stb), 32'h0);
    check_eq("rst_s_we", 32'(s_we), 32'h0);
    check_eq("rst_m_ack", 32'(m_ack), 32'h0);
    for (int i = 0; i < 3; i++) check_eq("rst_m_dat_o", m_rdat[i], 32'h0);
  endtask

  // Entered and left at a negedge; leaves the model at the start of the drain window.
  task automatic do_reset();
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    reset_checks();
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1'b0; cool[i] = 1'b0; txq[i].delete(); rx[i].delete();
      cur[i] = mk('0, 1'b0, 4'h0, 32'h0, 1);
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    owner = -1; t = 0; arb_at = DRAIN; starve = 0;
    prev_grant = 3'b000; first_grant_t = -1;
    grant_log.delete();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++) if (busy[i] || cool[i] || txq[i].size() > 0) return 1'b0;
    return owner < 0;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    if (!all_idle()) check_eq("wait_idle_timeout", 32'(n), 32'(budget + 1));
  endtask

  task automatic step_until_grant(input logic [2:0] g, input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      seen = (grant == g);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int m0_before;
    bit m2_hit;
    for (int i = 0; i < 3; i++) begin
      m_adr[i] = '0; m_wdat[i] = '0; m_sel[i] = '0; m_cti[i] = '0;
    end
    m_cyc = '0; m_stb = '0; m_we = '0; s_dat_i = 32'h5a5a_5a5a;
    @(negedge clk);
    do_reset();

    // M2 read after drain.
    run_idle(12);
    ack_mode = 1;
    txq[2].push_back(mk(24'h000100, 1'b0, 4'hf, 32'h0, 1));
    step_until_grant(3'b100, 10, seen);
    check_eq("t1_seen", 32'(seen), 32'h1);
    check_eq("t1_adr", 32'(s_adr), 32'h000100);
    wait_idle(20);
    check_eq("t1_rx2", 32'(rx[2].size()), 32'h1);
    check_eq("t1_rx01", 32'(rx[0].size() + rx[1].size()), 32'h0);

    // Simultaneous requests.
    grant_log.delete();
    for (int i = 0; i < 3; i++) txq[i].push_back(mk(24'(32'h400 + i * 4), 1'b0, 4'hf, 32'h0, 1));
    wait_idle(40);
    check_eq("t2_count", 32'(grant_log.size()), 32'h3);
    check_eq("t2_first", 32'((grant_log.size() > 0) ? grant_log[0] : 3'b0), 32'h1);
    check_eq("t2_second", 32'((grant_log.size() > 1) ? grant_log[1] : 3'b0), 32'h2);
    check_eq("t2_third", 32'((grant_log.size() > 2) ? grant_log[2] : 3'b0), 32'h4);

    // M0 burst while M1 waits.
    grant_log.delete();
    rx[0].delete();
    slave_data.push_back(32'hAAAA5555);
    slave_data.push_back(32'h1234ABCD);
    txq[0].push_back(mk(24'h000200, 1'b0, 4'hf, 32'h0, 2));
    txq[1].push_back(mk(24'h000300, 1'b0, 4'hf, 32'h0, 1));
    wait_idle(40);
    check_eq("t3_beats", 32'(rx[0].size()), 32'h2);
    check_eq("t3_beat0", (rx[0].size() > 0) ? rx[0][0] : 32'h0, 32'hAAAA5555);
    check_eq("t3_beat1", (rx[0].size() > 1) ? rx[0][1] : 32'h0, 32'h1234ABCD);
    check_eq("t3_order", 32'((grant_log.size() > 1) ? grant_log[1] : 3'b0), 32'h2);

    // M2 write.
    txq[2].push_back(mk(24'h000500, 1'b1, 4'b0011, 32'hDEADBEEF, 1));
    step_until_grant(3'b100, 10, seen);
    check_eq("t6_seen", 32'(seen), 32'h1);
    check_eq("t6_we", 32'(s_we), 32'h1);
    check_eq("t6_sel", 32'(s_sel), 32'h3);
    check_eq("t6_dat", s_dat_o, 32'hDEADBEEF);
    wait_idle(20);

    // M0 back-to-back against a waiting M2.
    grant_log.delete();
    for (int k = 0; k < 10; k++) txq[0].push_back(mk(24'(32'h800 + k * 4), 1'b0, 4'hf, 32'h0, 1));
    txq[2].push_back(mk(24'h000900, 1'b0, 4'hf, 32'h0, 1));
    wait_idle(200);
    m0_before = 0;
    m2_hit = 1'b0;
    foreach (grant_log[k]) begin
      if (grant_log[k] == 3'b100) m2_hit = 1'b1;
      if (!m2_hit && grant_log[k] == 3'b001) m0_before++;
    end
    check_eq("t5_m2_served", 32'(m2_hit), 32'h1);
`ifndef ARB_STARVE_GUARD_EN
    check_eq("t5_m0_first", 32'(m0_before), 32'd10);
`endif

    // Reset mid-cycle, then a stray ack during drain.
    ack_mode = 2;
    txq[1].push_back(mk(24'h000a00, 1'b0, 4'hf, 32'h0, 1));
    step_until_grant(3'b010, 10, seen);
    check_eq("t4_owned", 32'(s_cyc), 32'h1);
    do_reset();
    ack_mode = 1;
    stray_at = 3;
    txq[0].push_back(mk(24'h000b00, 1'b0, 4'hf, 32'h0, 1));
    wait_idle(40);
    stray_at = -1;
    check_eq("t4_first_grant", 32'(first_grant_t), 32'(DRAIN + 1));
    check_eq("t4_rx0", 32'(rx[0].size()), 32'h1);
    check_eq("t4_rx1", 32'(rx[1].size()), 32'h0);

    // Random traffic.
    ack_mode = 0;
    noise_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!busy[i] && txq[i].size() == 0 && $urandom_range(5) == 0)
          txq[i].push_back(mk(24'($urandom()), 1'($urandom()), 4'($urandom()), $urandom(),
                              int'($urandom_range(1, 2))));
      end
      step();
    end
    noise_en = 1'b0;
    wait_idle(400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic run_idle(input int n);
    repeat (n) step();
  endtask

endmodule
